// File: rtl/wash_scheduler.sv
// Round-robin scheduler that shares one wash unit among NREQ coin stations.
// Each station queues at most one job; a unit that never reports busy raises a fault that fault_clr clears.
module wash_scheduler #(
    parameter int NREQ = 4,
    parameter int TMO  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] dbl,
    input  logic            wash_done,
    input  logic            fault_clr,
    output logic            wash_start,
    output logic            wash_double,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] pending,
    output logic            fault
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TMO + 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] FAULT     = 3'd4;

    logic [2:0]      state;
    logic [NREQ-1:0] dbl_q;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   last;
    logic [IW-1:0]   cur;
    logic [IW-1:0]   winner;
    logic            found;
    int              idx;
    logic            retire;
    logic [NREQ-1:0] keep;
    logic [NREQ-1:0] take;

    // Scan downward so the closest station above 'last' is the one left standing.
    always_comb begin
        winner = last;
        found  = 1'b0;
        idx    = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (pending[idx[IW-1:0]]) begin
                winner = idx[IW-1:0];
                found  = 1'b1;
            end
        end
    end

    // A retiring station's bit is dropped before new coins are applied, so a
    // coin landing on the retire cycle re-queues the station with fresh dbl.
    assign retire = (state == RUN) && wash_done;
    assign keep   = pending & ~(retire ? grant : '0);
    assign take   = req & ~keep;

    assign wash_start = (state == START);
    assign fault      = (state == FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            dbl_q       <= '0;
            grant       <= '0;
            wash_double <= 1'b0;
            cnt         <= '0;
            cur         <= '0;
            last        <= IW'(NREQ - 1);
        end else begin
            pending <= keep | req;
            dbl_q   <= (dbl_q & ~take) | (dbl & take);
            case (state)
                IDLE: begin
                    if (found && wash_done) begin
                        grant       <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                        wash_double <= dbl_q[winner];
                        cur         <= winner;
                        state       <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!wash_done) begin
                        state <= RUN;
                    end else begin
                        if (cnt != CW'(TMO)) cnt <= cnt + CW'(1);
                        if (cnt + CW'(1) == CW'(TMO)) begin
                            state       <= FAULT;
                            grant       <= '0;
                            wash_double <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (wash_done) begin
                        last        <= cur;
                        grant       <= '0;
                        wash_double <= 1'b0;
                        state       <= IDLE;
                    end
                end
                FAULT: begin
                    if (fault_clr) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
